// File: rtl/fp_div_pkg.sv
// Shared types, flag positions and IEEE-754 constant patterns for the
// sequential FP divider and its rounding/packing stage.
package fp_div_pkg;

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

    localparam int FLG_INVALID   = 4;
    localparam int FLG_DIVZERO   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    // Patterns are built wide and size-cast by the user to 1+EXP_W+MAN_W bits.
    localparam int PAT_W = 128;

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [PAT_W-1:0] inf_pattern(input int exp_w, input int man_w);
        logic [PAT_W-1:0] one;
        one = PAT_W'(1);
        return ((one << exp_w) - one) << man_w;
    endfunction

    function automatic logic [PAT_W-1:0] qnan_pattern(input int exp_w, input int man_w);
        logic [PAT_W-1:0] one;
        one = PAT_W'(1);
        return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalises a 1.(MAN_W+2)-bit quotient, rounds to nearest-even and packs
// the IEEE word with overflow/underflow (flush-to-zero) and inexact flags.
module fp_round_pack
    import fp_div_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     sign,
    input  logic signed [EXP_W+1:0]  exp_in,
    input  logic [MAN_W+2:0]         quo,
    input  logic                     rem_nz,
    output logic [EXP_W+MAN_W:0]     word,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     inexact
);

    localparam logic [EXP_W+MAN_W-1:0] INF_MAG = (EXP_W+MAN_W)'(inf_pattern(EXP_W, MAN_W));
    localparam logic signed [EXP_W+1:0] ONE_S   = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] ZERO_S  = (EXP_W+2)'(0);
    localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);

    logic [MAN_W-1:0]        man;
    logic [MAN_W-1:0]        man_r;
    logic                    carry;
    logic                    guard;
    logic                    sticky;
    logic                    round_up;
    logic signed [EXP_W+1:0] exp_n;
    logic signed [EXP_W+1:0] exp_r;

    always_comb begin
        // A quotient below 1.0 is shifted up one place and the exponent drops by one.
        if (quo[MAN_W+2]) begin
            man    = quo[MAN_W+1:2];
            guard  = quo[1];
            sticky = quo[0] | rem_nz;
            exp_n  = exp_in;
        end else begin
            man    = quo[MAN_W:1];
            guard  = quo[0];
            sticky = rem_nz;
            exp_n  = exp_in - ONE_S;
        end

        round_up       = guard & (sticky | man[0]);
        {carry, man_r} = {1'b0, man} + (MAN_W+1)'(round_up);
        exp_r          = carry ? exp_n + ONE_S : exp_n;

        overflow  = (exp_r >= EXP_MAX);
        underflow = (exp_r <= ZERO_S);
        inexact   = overflow | underflow | guard | sticky;

        if (overflow) begin
            word = {sign, INF_MAG};
        end else if (underflow) begin
            word = {sign, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            word = {sign, exp_r[EXP_W-1:0], man_r};
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// Multi-cycle IEEE-754 divider: radix-2 restoring mantissa division, one
// quotient bit per cycle, fixed latency, valid/ready on both sides.
module fp_div_seq
    import fp_div_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data,
    output logic [4:0]             out_flags
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int CNT_W = $clog2(MAN_W + 3);
    localparam logic [CNT_W-1:0]        LAST_STEP = CNT_W'(MAN_W + 2);
    localparam logic [EXP_W-1:0]        EXP_ONES  = '1;
    localparam logic signed [EXP_W+1:0] BIAS      = (EXP_W+2)'(exp_bias(EXP_W));
    localparam logic [W-1:0]            QNAN      = W'(qnan_pattern(EXP_W, MAN_W));
    localparam logic [W-2:0]            INF_MAG   = (W-1)'(inf_pattern(EXP_W, MAN_W));

    state_t                  state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    in_ready_reg;
    logic                    out_valid_reg;
    logic [W-1:0]            out_data_reg;
    logic [4:0]              out_flags_reg;

    logic                    sign_reg;
    logic signed [EXP_W+1:0] exp_reg;
    logic [MAN_W:0]          mb_reg;
    logic [MAN_W+1:0]        rem_reg;
    logic [MAN_W+2:0]        quo_reg;
    logic                    spec_reg;
    logic [W-1:0]            spec_word_reg;
    logic [4:0]              spec_flags_reg;

    // Operand classification for the capture cycle (subnormals read as zero).
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             sign_in;
    logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic             spec_next;
    logic [W-1:0]     spec_word_next;
    logic [4:0]       spec_flags_next;
    logic signed [EXP_W+1:0] exp_next;

    always_comb begin
        ea      = in_a[W-2:MAN_W];
        eb      = in_b[W-2:MAN_W];
        fa      = in_a[MAN_W-1:0];
        fb      = in_b[MAN_W-1:0];
        sign_in = in_a[W-1] ^ in_b[W-1];
        nan_a   = (ea == EXP_ONES) && (fa != '0);
        nan_b   = (eb == EXP_ONES) && (fb != '0);
        inf_a   = (ea == EXP_ONES) && (fa == '0);
        inf_b   = (eb == EXP_ONES) && (fb == '0);
        zero_a  = (ea == '0);
        zero_b  = (eb == '0);
        exp_next = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;

        spec_next       = 1'b1;
        spec_word_next  = '0;
        spec_flags_next = '0;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            spec_word_next               = QNAN;
            spec_flags_next[FLG_INVALID] = 1'b1;
        end else if (inf_a) begin
            spec_word_next = {sign_in, INF_MAG};
        end else if (zero_b) begin
            spec_word_next               = {sign_in, INF_MAG};
            spec_flags_next[FLG_DIVZERO] = 1'b1;
        end else if (inf_b || zero_a) begin
            spec_word_next = {sign_in, {(W-1){1'b0}}};
        end else begin
            spec_next = 1'b0;
        end
    end

    // Restoring step: trial-subtract the divisor, keep the difference when it
    // is non-negative, and shift the partial remainder for the next bit.
    logic [MAN_W+2:0] trial;
    logic             q_bit;
    logic [MAN_W+1:0] rem_next;

    always_comb begin
        trial    = {1'b0, rem_reg} - {2'b00, mb_reg};
        q_bit    = ~trial[MAN_W+2];
        rem_next = (q_bit ? trial[MAN_W+1:0] : rem_reg) << 1;
    end

    logic [W-1:0] rp_word;
    logic         rp_overflow, rp_underflow, rp_inexact;
    logic [4:0]   calc_flags;

    fp_round_pack #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round_pack (
        .sign      (sign_reg),
        .exp_in    (exp_reg),
        .quo       (quo_reg),
        .rem_nz    (rem_reg != '0),
        .word      (rp_word),
        .overflow  (rp_overflow),
        .underflow (rp_underflow),
        .inexact   (rp_inexact)
    );

    always_comb begin
        calc_flags                = '0;
        calc_flags[FLG_OVERFLOW]  = rp_overflow;
        calc_flags[FLG_UNDERFLOW] = rp_underflow;
        calc_flags[FLG_INEXACT]   = rp_inexact;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_flags_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    in_ready_reg <= 1'b1;
                    if (in_valid && in_ready_reg) begin
                        in_ready_reg   <= 1'b0;
                        sign_reg       <= sign_in;
                        exp_reg        <= exp_next;
                        mb_reg         <= {1'b1, fb};
                        rem_reg        <= {2'b01, fa};
                        quo_reg        <= '0;
                        spec_reg       <= spec_next;
                        spec_word_reg  <= spec_word_next;
                        spec_flags_reg <= spec_flags_next;
                        cnt_reg        <= '0;
                        state_reg      <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem_reg <= rem_next;
                    quo_reg <= {quo_reg[MAN_W+1:0], q_bit};
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_STEP) begin
                        state_reg <= ROUND;
                    end
                end
                ROUND: begin
                    out_data_reg  <= spec_reg ? spec_word_reg  : rp_word;
                    out_flags_reg <= spec_reg ? spec_flags_reg : calc_flags;
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_flags = out_flags_reg;

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: directed vectors, random operands against a real-
// arithmetic reference, backpressure, mid-division reset and a double run.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_data;
    logic [4:0]  out_flags;

    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [63:0] d_in_a, d_in_b, d_out_data;
    logic [4:0]  d_out_flags;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fp_div_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags)
    );

    fp_div_seq #(.EXP_W(11), .MAN_W(52)) dut_d (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_a(d_in_a), .in_b(d_in_b),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_data(d_out_data), .out_flags(d_out_flags)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference: divide the significands as reals, then round the correctly
    // rounded double quotient to single precision (nearest-even).
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [4:0] f);
        logic        sg, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, g, st;
        real         ma, mb, q;
        logic [63:0] qb;
        logic [23:0] kept;
        int          s;
        sg     = a[31] ^ b[31];
        nan_a  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nan_b  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        inf_a  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        inf_b  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        zero_a = (a[30:23] == 0);
        zero_b = (b[30:23] == 0);
        f = 5'b0;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            r = 32'h7FC00000; f = 5'b10000;
        end else if (inf_a) begin
            r = {sg, 8'hFF, 23'b0};
        end else if (zero_b) begin
            r = {sg, 8'hFF, 23'b0}; f = 5'b01000;
        end else if (inf_b || zero_a) begin
            r = {sg, 31'b0};
        end else begin
            ma   = 1.0 + real'(int'(a[22:0])) / 8388608.0;
            mb   = 1.0 + real'(int'(b[22:0])) / 8388608.0;
            q    = ma / mb;
            qb   = $realtobits(q);
            s    = int'(a[30:23]) - int'(b[30:23]) + 127 + (int'(qb[62:52]) - 1023);
            g    = qb[28];
            st   = |qb[27:0];
            kept = {1'b0, qb[51:29]} + 24'(g & (st | qb[29]));
            if (kept[23]) s = s + 1;
            if (s >= 255) begin
                r = {sg, 8'hFF, 23'b0}; f = 5'b00101;
            end else if (s <= 0) begin
                r = {sg, 31'b0}; f = 5'b00011;
            end else begin
                r = {sg, 8'(s), kept[22:0]}; f = {4'b0, g | st};
            end
        end
    endfunction

    function automatic logic [31:0] gen_operand();
        int unsigned k;
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        k = $urandom_range(0, 15);
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        case (k)
            0:       begin e = 8'h00; f = 23'd0; end
            1:       begin e = 8'hFF; f = 23'd0; end
            2:       begin e = 8'hFF; f = f | 23'd1; end
            3:       begin e = 8'h00; f = f | 23'd1; end
            4, 5:    e = 8'($urandom_range(1, 254));
            6:       begin e = 8'($urandom_range(100, 154)); f = 23'd0; end
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {s, e, f};
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [4:0] fl, output int lat);
        int wait_cnt;
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        res = out_data;
        fl  = out_flags;
    endtask

    task automatic consume(input string tag);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] da [7];
        logic [31:0] db [7];
        logic [31:0] dr [7];
        logic [4:0]  df [7];
        logic [31:0] res, exp_r, r0;
        logic [4:0]  fl, exp_f, f0;
        logic [31:0] a, b;
        int          lat, wcnt;
        logic        stable, ready_low, valid_hi, seen;

        da = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h00000000,
               32'hFF800000, 32'h7F7FFFFF, 32'h00800000};
        db = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000,
               32'h40000000, 32'h3E800000, 32'h40000000};
        dr = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'h7FC00000,
               32'hFF800000, 32'h7F800000, 32'h00000000};
        df = '{5'b00000, 5'b00001, 5'b01000, 5'b10000,
               5'b00000, 5'b00101, 5'b00011};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        d_in_valid = 1'b0; d_out_ready = 1'b0; d_in_a = '0; d_in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_flags", 64'(out_flags), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 check("in_ready_after_rst", 64'(in_ready), 64'd1);

        for (int i = 0; i < 7; i++) begin
            do_op(da[i], db[i], res, fl, lat);
            $display("dir%0d: %h / %h -> %h flags %b lat %0d", i, da[i], db[i], res, fl, lat);
            check($sformatf("dir%0d_data", i),    64'(res), 64'(dr[i]));
            check($sformatf("dir%0d_flags", i),   64'(fl),  64'(df[i]));
            check($sformatf("dir%0d_latency", i), 64'(lat), 64'd27);
            consume($sformatf("dir%0d", i));
        end

        // Backpressure: result must hold while the consumer stalls.
        do_op(32'h40C00000, 32'h40000000, r0, f0, lat);
        stable = 1'b1; ready_low = 1'b1; valid_hi = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            stable    = stable & (out_data === r0) & (out_flags === f0);
            ready_low = ready_low & (in_ready === 1'b0);
            valid_hi  = valid_hi & (out_valid === 1'b1);
        end
        $display("bp: data %h flags %b held through 10 stalled cycles", r0, f0);
        check("bp_data",      64'(r0),        64'h40400000);
        check("bp_stable",    64'(stable),    64'd1);
        check("bp_ready_low", 64'(ready_low), 64'd1);
        check("bp_valid_hi",  64'(valid_hi),  64'd1);
        consume("bp");

        for (int i = 0; i < 40; i++) begin
            a = gen_operand();
            b = gen_operand();
            ref_div(a, b, exp_r, exp_f);
            do_op(a, b, res, fl, lat);
            $display("rnd%0d: %h / %h -> %h flags %b (ref %h %b)", i, a, b, res, fl, exp_r, exp_f);
            check($sformatf("rnd%0d_data", i),    64'(res), 64'(exp_r));
            check($sformatf("rnd%0d_flags", i),   64'(fl),  64'(exp_f));
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'd27);
            consume($sformatf("rnd%0d", i));
        end

        // Reset in the tenth DIVIDE cycle aborts the operation.
        @(negedge clk);
        in_a = 32'h40C00000; in_b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 check("midrst_in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 check("midrst_in_ready_back", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 seen = seen | out_valid;
        end
        $display("midrst: out_valid seen after abort = %0b", seen);
        check("midrst_no_result", 64'(seen), 64'd0);
        do_op(32'h3F800000, 32'h40400000, res, fl, lat);
        $display("post_rst: %h flags %b lat %0d", res, fl, lat);
        check("post_rst_data",    64'(res), 64'h3EAAAAAB);
        check("post_rst_latency", 64'(lat), 64'd27);
        consume("post_rst");

        // Double precision instance: 6.0 / 2.0.
        @(negedge clk);
        d_in_a = 64'h4018000000000000; d_in_b = 64'h4000000000000000; d_in_valid = 1'b1;
        wcnt = 0;
        while (!d_in_ready && wcnt < 100) begin
            @(negedge clk);
            wcnt++;
        end
        if (!d_in_ready) check("dbl_accept_timeout", 64'(d_in_ready), 64'd1);
        @(posedge clk);
        #1 d_in_valid = 1'b0;
        lat = 0;
        while (!d_out_valid && lat < 300) begin
            @(posedge clk);
            #1 lat++;
        end
        $display("dbl: %h flags %b lat %0d", d_out_data, d_out_flags, lat);
        check("dbl_data",    d_out_data,         64'h4008000000000000);
        check("dbl_flags",   64'(d_out_flags),   64'd0);
        check("dbl_latency", 64'(lat),           64'd56);
        @(negedge clk) d_out_ready = 1'b1;
        @(posedge clk);
        #1 d_out_ready = 1'b0;
        check("dbl_ready_back", 64'(d_in_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
